// File: rtl/sparc_mem_sequencer.sv
// sparc_mem_sequencer: Moore sequencer for datapath RAM accesses with alignment and timeout errors
module sparc_mem_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Req,
  input  logic       RW,
  input  logic [1:0] Size,
  input  logic [1:0] AddrLo,
  input  logic       RamReady,
  output logic       MAR_Ld,
  output logic       MDR_Ld,
  output logic       MDR_Sel,
  output logic       RamEnable,
  output logic       RamRW,
  output logic [1:0] RamSize,
  output logic       MOC,
  output logic       Busy,
  output logic       AlignErr,
  output logic       Timeout
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, COMPLETE, FAULT} state_t;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic rw_q, align_err, timeout;
  logic [1:0] size_q;
  logic mis, last_wait;
  assign mis = (Size == 2'b11) || (Size == 2'b01 && AddrLo[0]) || (Size == 2'b10 && AddrLo != 2'b00);
  assign last_wait = cnt == CNT_W'(MAX_WAIT - 1);
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state     <= IDLE;
      cnt       <= '0;
      rw_q      <= 1'b0;
      size_q    <= 2'b00;
      align_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && Req) begin
        rw_q      <= RW;
        size_q    <= Size;
        align_err <= mis;
        timeout   <= 1'b0;
      end
      if (state == SETUP) cnt <= '0;
      else if (state == ACCESS && !RamReady && !last_wait && cnt != '1) cnt <= cnt + 1'b1;
      if (state == ACCESS && !RamReady && last_wait) timeout <= 1'b1;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = !Req ? IDLE : (mis ? FAULT : SETUP);
      SETUP:    next = ACCESS;
      ACCESS:   next = RamReady ? COMPLETE : (last_wait ? FAULT : ACCESS);
      default:  next = IDLE;
    endcase
  end
  always_comb begin
    MAR_Ld    = state == SETUP;
    MDR_Ld    = (state == SETUP && !rw_q) || (state == COMPLETE && rw_q);
    MDR_Sel   = state == COMPLETE && rw_q;
    RamEnable = state == ACCESS;
    RamRW     = rw_q;
    RamSize   = size_q;
    MOC       = state == COMPLETE || state == FAULT;
    Busy      = state != IDLE;
    AlignErr  = align_err;
    Timeout   = timeout;
  end
endmodule

// File: tb/tb_sparc_mem_sequencer.sv
// tb_sparc_mem_sequencer: randomized cycle-by-cycle check of sparc_mem_sequencer against a transaction-level model
module tb_sparc_mem_sequencer;
  localparam int MAX_WAIT = 15;
  logic Clk = 0, Clr = 0, Req = 0, RW = 0, RamReady = 0;
  logic [1:0] Size = 0, AddrLo = 0;
  logic MAR_Ld, MDR_Ld, MDR_Sel, RamEnable, RamRW, MOC, Busy, AlignErr, Timeout;
  logic [1:0] RamSize;
  int checks = 0, failures = 0;
  logic m_rw = 0, m_ae = 0, m_to = 0;
  logic [1:0] m_size = 0;
  logic [10:0] obs_q[$], exp_q[$];

  sparc_mem_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .Clk(Clk), .Clr(Clr), .Req(Req), .RW(RW), .Size(Size), .AddrLo(AddrLo), .RamReady(RamReady),
    .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld), .MDR_Sel(MDR_Sel), .RamEnable(RamEnable), .RamRW(RamRW),
    .RamSize(RamSize), .MOC(MOC), .Busy(Busy), .AlignErr(AlignErr), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  wire [10:0] obs = {MAR_Ld, MDR_Ld, MDR_Sel, RamEnable, RamRW, RamSize, MOC, Busy, AlignErr, Timeout};

  // One transaction: d = RamReady-low cycles in ACCESS; records every cycle through the following IDLE.
  task automatic run_access(input logic rw, input logic [1:0] sz, input logic [1:0] al, input int d,
                            input bit drop, input bit hold);
    bit mis, to, last, idle, setup, access, rd_done;
    int acc, n;
    mis = sz == 2'b11 || (sz == 2'b01 && al[0]) || (sz == 2'b10 && al != 2'b00);
    acc = (d + 1 < MAX_WAIT) ? d + 1 : MAX_WAIT;
    to  = !mis && d >= MAX_WAIT;
    n   = mis ? 1 : acc + 2;
    obs_q.delete();
    exp_q.delete();
    @(negedge Clk);
    Req = 1; RW = rw; Size = sz; AddrLo = al; RamReady = 1'($urandom);
    m_rw = rw; m_size = sz; m_ae = mis; m_to = 0;
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge Clk); #1;
      last    = k == n;
      idle    = k == n + 1;
      setup   = !mis && k == 1;
      access  = !mis && k > 1 && k < n;
      rd_done = last && !mis && !to && rw;
      if (last && to) m_to = 1;
      obs_q.push_back(obs);
      exp_q.push_back({setup, (setup && !rw) || rd_done, rd_done, access, m_rw, m_size, last, !idle, m_ae, m_to});
      RW = 1'($urandom); Size = 2'($urandom); AddrLo = 2'($urandom);
      RamReady = access ? (k - 1 > d) : 1'($urandom);
      if (drop && !idle) Req = 0;
      if (last) Req = hold;
    end
  endtask

  task automatic test_reset();
    Clr = 1;
    #1;
    checks++;
    if (obs !== 11'b0) begin failures++; $display("FAIL reset_t0 got=%b exp=%b", obs, 11'b0); end
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (obs !== 11'b0) begin failures++; $display("FAIL reset_held got=%b exp=%b", obs, 11'b0); end
    @(negedge Clk);
    Clr = 0;
  endtask

  task automatic test_word_read();
    run_access(1, 2'b10, 2'b00, 0, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL word_read cyc%0d got=%b exp=%b", i + 1, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_halfword_write();
    run_access(0, 2'b01, 2'b10, 3, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL hw_write cyc%0d got=%b exp=%b", i + 1, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_misaligned();
    logic [1:0] szs[3] = '{2'b10, 2'b11, 2'b00};
    logic [1:0] als[3] = '{2'b10, 2'b00, 2'b11};
    for (int t = 0; t < 3; t++) begin
      run_access(1'(t), szs[t], als[t], 1, 0, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL misalign%0d cyc%0d got=%b exp=%b", t, i + 1, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    int ds[2] = '{MAX_WAIT, MAX_WAIT - 1};
    for (int t = 0; t < 2; t++) begin
      run_access(1, 2'b10, 2'b00, ds[t], 0, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL timeout_d%0d cyc%0d got=%b exp=%b", ds[t], i + 1, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_clr_mid_access();
    bit saw_moc;
    saw_moc = 0;
    @(negedge Clk);
    Req = 1; RW = 1; Size = 2'b10; AddrLo = 2'b00; RamReady = 0;
    repeat (4) @(posedge Clk);
    #3;
    Clr = 1;
    #1;
    checks++;
    if (obs !== 11'b0) begin failures++; $display("FAIL clr_async got=%b exp=%b", obs, 11'b0); end
    @(negedge Clk);
    Req = 0;
    repeat (2) begin
      @(posedge Clk); #1;
      saw_moc |= MOC;
    end
    checks++;
    if (saw_moc !== 1'b0) begin failures++; $display("FAIL clr_no_moc got=%b exp=0", saw_moc); end
    @(negedge Clk);
    Clr = 0;
    m_rw = 0; m_size = 0; m_ae = 0; m_to = 0;
    run_access(0, 2'b00, 2'b01, 2, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL clr_recover cyc%0d got=%b exp=%b", i + 1, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      run_access(1'(t), 2'(t), 2'b00, t, t == 2, t != 3);
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b%0d cyc%0d got=%b exp=%b", t, i + 1, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_access(1'($urandom), 2'($urandom), 2'($urandom), int'($urandom_range(0, 17)),
                 1'($urandom), t != 39 && 1'($urandom));
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d cyc%0d got=%b exp=%b", t, i + 1, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_halfword_write();
    test_misaligned();
    test_timeout();
    test_clr_mid_access();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sparc_mem_sequencer.md
Name: sparc_mem_sequencer

Overview:
Moore-style sequencer that runs every datapath memory access between the control unit and the SPARC RAM. It loads MAR and MDR, drives RAM enable, read/write and size, and waits on RAM ready with a bounded wait-state counter. It returns MOC to the control unit when the access finishes. It also detects misaligned accesses and RAM timeouts, and reports both as sticky error flags.

Parameters:
MAX_WAIT, 15, maximum ACCESS cycles with RamReady low before timeout (1..2^CNT_W-1)
CNT_W, 4, width of the wait-state counter

Ports:
Clk  input  1  system clock, rising-edge active
Clr  input  1  reset, asynchronous, active-high
Req  input  1  access request from control unit; held until MOC
RW  input  1  1=read (load), 0=write (store)
Size  input  2  00=byte, 01=halfword, 10=word, 11=reserved
AddrLo  input  2  Addr[1:0] of the effective address, for alignment check
RamReady  input  1  RAM data valid / write accepted
MAR_Ld  output  1  MAR load enable
MDR_Ld  output  1  MDR load enable
MDR_Sel  output  1  MDR source mux: 0=datapath bus, 1=RAM data out
RamEnable  output  1  RAM chip enable
RamRW  output  1  RAM direction, latched RW
RamSize  output  2  RAM access size, latched Size
MOC  output  1  memory operation complete, one-cycle pulse
Busy  output  1  high in any state except IDLE
AlignErr  output  1  sticky misaligned-access flag
Timeout  output  1  sticky RAM timeout flag

Behaviour:
- Reset (Clr=1, async): state=IDLE, counter=0, latched RW/Size=0; AlignErr=Timeout=0.
- Reset values of the remaining outputs: MAR_Ld, MDR_Ld, MDR_Sel, RamEnable, RamRW, RamSize, MOC and Busy all 0. Clr mid-access aborts it with no MOC.
- Outputs decode from the state register only (Moore). RamRW and RamSize come from the latched copies.
- States: IDLE, SETUP, ACCESS, COMPLETE, FAULT.
- IDLE: all strobes 0. At a rising edge with Req=1, latch RW and Size and clear AlignErr and Timeout.
  - Misaligned if Size=11, or Size=01 with AddrLo[0]=1, or Size=10 with AddrLo!=00. Misaligned sets AlignErr=1 and goes to FAULT.
  - Aligned goes to SETUP.
- SETUP (1 cycle): MAR_Ld=1. For a write, MDR_Ld=1 and MDR_Sel=0. Counter cleared. Next state ACCESS.
- ACCESS: RamEnable=1.
  - RamReady=1 at the edge: go to COMPLETE. RamReady wins over timeout in the same cycle.
  - RamReady=0 and counter==MAX_WAIT-1: set Timeout=1 and go to FAULT.
  - Otherwise counter+1 and stay in ACCESS.
  - ACCESS therefore lasts at most MAX_WAIT cycles.
- COMPLETE (1 cycle): MOC=1. For a read, MDR_Ld=1 and MDR_Sel=1. Next state IDLE.
- FAULT (1 cycle): MOC=1, no RAM enable, no MDR load. Next state IDLE.
- Error flags stay set until the next accepted request or Clr.
- Latency from Req sampled to MOC high: 3 cycles with zero wait states, plus one cycle per wait state. An aligned-check fault gives MOC 1 cycle after Req is sampled.
- Req deasserting after acceptance is ignored; the access completes.
- Req still high in COMPLETE or FAULT is not re-sampled until IDLE. Back-to-back accesses therefore take at least 4 cycles each.
- RW, Size and AddrLo are sampled only at acceptance. Later changes have no effect.
- The counter saturates and never wraps. It is only meaningful in ACCESS.

Test Plan:
- Clr pulse at t=0 -> all outputs 0, Busy=0.
- Word read, AddrLo=00, RamReady=1 always -> Busy=1, MAR_Ld in cycle 1, RamEnable in cycle 2, MOC+MDR_Ld+MDR_Sel=1 in cycle 3; no errors.
- Halfword write, AddrLo=10, RamReady rises after 3 ACCESS cycles -> MDR_Ld with MDR_Sel=0 in SETUP, RamEnable high 4 cycles, RamRW=0, RamSize=01, MOC on the 6th cycle.
- Word access with AddrLo=10, and also Size=11 -> AlignErr=1, MOC 1 cycle after Req, RamEnable and MAR_Ld never asserted; next aligned request clears AlignErr.
- MAX_WAIT=15, RamReady held 0 -> RamEnable high exactly 15 cycles, Timeout=1 with MOC pulse. Repeat with RamReady=1 on the 15th ACCESS cycle -> COMPLETE, Timeout=0.
- Clr asserted mid-ACCESS, between clock edges -> outputs 0 immediately, no MOC. New request after Clr release completes normally.
